aibcr3_rambit_loader: RTL and testbench

- Serial configuration loader directly upstream of the per-bit rambit buffers.
- Accepts a bit-serial config stream with valid/ready handshake, assembles it into a shadow register and checks one trailing even-parity bit.
- Commits atomically to the parallel rambit outputs, one per downstream buffer, only when the frame is complete and parity is good. Rambit outputs never show a partial frame.

---
 rtl/aibcr3_rambit_pkg.sv | 21 ++
 rtl/aibcr3_rambit_shreg.sv | 33 +++
 rtl/aibcr3_rambit_loader.sv | 134 +++++++++++++
 tb/tb_aibcr3_rambit_loader.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/aibcr3_rambit_pkg.sv
// Shared types and helpers for the rambit serial configuration loader.
package aibcr3_rambit_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_PARITY,
    ST_CHECK,
    ST_COMMIT
  } state_t;

  localparam logic PARITY_EVEN = 1'b0;

  function automatic int clog2(input int value);
    int w;
    w = 0;
    while ((1 << w) < value) w++;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/aibcr3_rambit_shreg.sv
// Shadow register for the loader: one bit written per accepted serial transfer.
module aibcr3_rambit_shreg
  import aibcr3_rambit_pkg::*;
#(
  parameter int NBITS = 16,
  parameter int IW    = clog2(NBITS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_we,
  input  logic [IW-1:0]    i_idx,
  input  logic             i_d,
  output logic [NBITS-1:0] o_q
);

  logic [NBITS-1:0] r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= '0;
    end else if (i_clr) begin
      r_q <= '0;
    end else if (i_we) begin
      for (int k = 0; k < NBITS; k++) begin
        if (i_idx == IW'(k)) r_q[k] <= i_d;
      end
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/aibcr3_rambit_loader.sv
// Serial config loader: assembles a frame, checks even parity, commits atomically to rambit_q.
module aibcr3_rambit_loader
  import aibcr3_rambit_pkg::*;
#(
  parameter int               NBITS     = 16,
  parameter logic [NBITS-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_start,
  input  logic             cfg_abort,
  input  logic             cfg_sdata,
  input  logic             cfg_svalid,
  output logic             cfg_sready,
  output logic             busy,
  output logic             cfg_done,
  output logic             cfg_err,
  output logic [NBITS-1:0] rambit_q
);

  localparam int CNT_W = clog2(NBITS + 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_par;
  logic             r_sready;
  logic             r_busy;
  logic             r_done;
  logic             r_err;
  logic [NBITS-1:0] r_rambit;

  logic             w_xfer;
  logic             w_clr;
  logic             w_we;
  logic             w_good;
  logic [NBITS-1:0] w_shadow;

  assign w_xfer = cfg_svalid & r_sready;
  assign w_clr  = (r_state == ST_IDLE) & cfg_start & ~cfg_abort;
  // Abort discards a bit arriving in the same cycle.
  assign w_we   = (r_state == ST_SHIFT) & w_xfer & ~cfg_abort;
  assign w_good = ((^w_shadow) ^ r_par) == PARITY_EVEN;

  aibcr3_rambit_shreg #(
    .NBITS (NBITS),
    .IW    (CNT_W)
  ) u_shreg (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_clr),
    .i_we  (w_we),
    .i_idx (r_cnt),
    .i_d   (cfg_sdata),
    .o_q   (w_shadow)
  );

  // Outputs are registered against the next state, so they track r_state exactly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_par    <= 1'b0;
      r_sready <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_rambit <= RESET_VAL;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (cfg_start && !cfg_abort) begin
            r_state  <= ST_SHIFT;
            r_cnt    <= '0;
            r_err    <= 1'b0;
            r_sready <= 1'b1;
            r_busy   <= 1'b1;
          end
        end
        ST_SHIFT: begin
          if (cfg_abort) begin
            r_state  <= ST_IDLE;
            r_sready <= 1'b0;
            r_busy   <= 1'b0;
          end else if (w_xfer) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == CNT_W'(NBITS - 1)) r_state <= ST_PARITY;
          end
        end
        ST_PARITY: begin
          if (cfg_abort) begin
            r_state  <= ST_IDLE;
            r_sready <= 1'b0;
            r_busy   <= 1'b0;
          end else if (w_xfer) begin
            r_par    <= cfg_sdata;
            r_state  <= ST_CHECK;
            r_sready <= 1'b0;
          end
        end
        ST_CHECK: begin
          if (cfg_abort) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else if (w_good) begin
            r_state  <= ST_COMMIT;
            r_rambit <= w_shadow;
            r_done   <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
            r_err   <= 1'b1;
            r_busy  <= 1'b0;
          end
        end
        ST_COMMIT: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state  <= ST_IDLE;
          r_sready <= 1'b0;
          r_busy   <= 1'b0;
        end
      endcase
    end
  end

  assign cfg_sready = r_sready;
  assign busy       = r_busy;
  assign cfg_done   = r_done;
  assign cfg_err    = r_err;
  assign rambit_q   = r_rambit;

endmodule

// File: tb/tb_aibcr3_rambit_loader.sv
// Randomized self-checking bench for the rambit loader against a frame-level model.
module tb_aibcr3_rambit_loader;

  localparam int         NBITS = 8;
  localparam logic [7:0] RVAL  = 8'hA5;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_start, cfg_abort, cfg_sdata, cfg_svalid;
  logic       cfg_sready, busy, cfg_done, cfg_err;
  logic [7:0] rambit_q;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] m_q;
  logic       m_err;

  aibcr3_rambit_loader #(
    .NBITS     (NBITS),
    .RESET_VAL (RVAL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_start  (cfg_start),
    .cfg_abort  (cfg_abort),
    .cfg_sdata  (cfg_sdata),
    .cfg_svalid (cfg_svalid),
    .cfg_sready (cfg_sready),
    .busy       (busy),
    .cfg_done   (cfg_done),
    .cfg_err    (cfg_err),
    .rambit_q   (rambit_q)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_checks(input string tag);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_sready"}, cfg_sready, 1'b0);
    chk({tag, "_done"}, cfg_done, 1'b0);
    chk({tag, "_err"}, cfg_err, m_err);
    chk({tag, "_q"}, rambit_q, m_q);
  endtask

  // abort_idx: 0..8 abort with that bit's transfer, 9 in CHECK, 10 in COMMIT, -1 none.
  task automatic frame(input logic [7:0] data, input logic par, input int stall_idx,
                       input int stall_len, input int pre_par_len, input int abort_idx);
    logic [8:0] bits;
    bit         good;
    int         slen;
    bits = {par, data};
    good = ((($countones(data) + int'(par)) % 2) == 0);
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    m_err = 1'b0;
    chk("start_busy", busy, 1'b1);
    chk("start_err_clr", cfg_err, 1'b0);
    for (int i = 0; i < 9; i++) begin
      slen = (i == stall_idx) ? stall_len : 0;
      if (i == 8) slen += pre_par_len;
      for (int s = 0; s < slen; s++) begin
        cfg_svalid = 1'b0;
        cfg_sdata  = 1'($urandom);
        cfg_start  = 1'($urandom);
        tick();
        chk("stall_busy", busy, 1'b1);
      end
      cfg_start  = 1'b0;
      cfg_svalid = 1'b1;
      cfg_sdata  = bits[i];
      chk("sready", cfg_sready, 1'b1);
      if (i == abort_idx) begin
        cfg_abort = 1'b1;
        tick();
        cfg_abort  = 1'b0;
        cfg_svalid = 1'b0;
        for (int k = 0; k < 3; k++) begin
          idle_checks("abort");
          tick();
        end
        return;
      end
      tick();
    end
    cfg_svalid = 1'b0;
    chk("chk_sready", cfg_sready, 1'b0);
    chk("chk_done", cfg_done, 1'b0);
    chk("chk_busy", busy, 1'b1);
    chk("chk_q", rambit_q, m_q);
    if (abort_idx == 9) cfg_abort = 1'b1;
    tick();
    cfg_abort = 1'b0;
    if (abort_idx == 9) begin
      idle_checks("abort_chk");
      return;
    end
    if (good) begin
      m_q = data;
      chk("commit_done", cfg_done, 1'b1);
      chk("commit_q", rambit_q, m_q);
      chk("commit_busy", busy, 1'b1);
      if (abort_idx == 10) cfg_abort = 1'b1;
      tick();
      cfg_abort = 1'b0;
      idle_checks("post_commit");
    end else begin
      m_err = 1'b1;
      idle_checks("bad_par");
      tick();
      tick();
      idle_checks("bad_par_sticky");
    end
  endtask

  initial begin
    logic [7:0] d;
    logic       p;
    int         ab;
    rst = 1'b1;
    cfg_start = 1'b0; cfg_abort = 1'b0; cfg_sdata = 1'b0; cfg_svalid = 1'b0;
    m_q = RVAL;
    m_err = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    idle_checks("reset");
    tick();
    idle_checks("reset_hold");

    // svalid in IDLE is ignored; start with abort stays idle
    cfg_svalid = 1'b1;
    cfg_sdata  = 1'b1;
    tick();
    cfg_svalid = 1'b0;
    idle_checks("idle_valid");
    cfg_start = 1'b1;
    cfg_abort = 1'b1;
    tick();
    cfg_start = 1'b0;
    cfg_abort = 1'b0;
    idle_checks("start_abort");

    frame(8'h3C, 1'b0, -1, 0, 0, -1);
    frame(8'h3C, 1'b1, -1, 0, 0, -1);
    frame(8'h81, 1'b0, 3, 3, 5, -1);
    frame(8'h5A, 1'b0, 4, 2, 0, 7);
    frame(8'h01, 1'b1, -1, 0, 0, 10);

    for (int n = 0; n < 30; n++) begin
      d  = 8'($urandom);
      p  = 1'(($countones(d) % 2) != 0);
      if ($urandom_range(0, 3) == 0) p = ~p;
      ab = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 10)) : -1;
      frame(d, p, int'($urandom_range(0, 9)), int'($urandom_range(0, 4)),
            int'($urandom_range(0, 2)), ab);
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
        tick();
        idle_checks("gap");
      end
    end

    // asynchronous reset in the middle of a frame
    frame(8'h3C, 1'b0, -1, 0, 0, -1);
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cfg_svalid = 1'b1;
      cfg_sdata  = 1'b1;
      tick();
    end
    cfg_svalid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    m_q   = RVAL;
    m_err = 1'b0;
    idle_checks("async_rst");
    tick();
    rst = 1'b0;
    idle_checks("async_rst_rel");
    frame(8'h0F, 1'b0, -1, 0, 0, -1);
    chk("final_q", rambit_q, 8'h0F);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
